// File: rtl/pcie_tx_ab_commit_arb_if.sv
// AXI-Stream bundle between the AFU TX pipelines, this arbiter and the PCIe SS.
// Sink is the receiving side (drives tready); source drives the beat.
interface pcie_ss_axis_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic [USER_W-1:0]     tuser_vendor;

    modport source (output tvalid, tlast, tdata, tkeep, tuser_vendor, input  tready);
    modport sink   (input  tvalid, tlast, tdata, tkeep, tuser_vendor, output tready);
endinterface

// File: rtl/pcie_tx_ab_commit_arb.sv
// Packet-granular merge of AFU TX A and TX B into one TLP stream, emitting a
// write-commit record (tag + PF/VF) for every TX A memory write that wins.
package pcie_ss_hdr_pkg;
    typedef struct packed {
        logic [10:0] vf_num;
        logic        vf_active;
        logic [2:0]  pf_num;
    } ReqHdr_pf_vf_info_t;

    typedef struct packed {
        logic [132:0] rsvd_hi;
        logic [63:0]  host_addr;
        logic [15:0]  req_id;
        logic [10:0]  vf_num;
        logic         vf_active;
        logic [2:0]   pf_num;
        logic [9:0]   length;
        logic [7:0]   tag_l;
        logic         tag_m;
        logic         tag_h;
        logic [7:0]   fmt_type;
    } PCIe_ReqHdr_t;

    function automatic logic func_is_mwr_req(input logic [7:0] fmt_type);
        return (fmt_type == 8'h40) || (fmt_type == 8'h60);
    endfunction
endpackage

module pcie_tx_ab_commit_arb #(
    parameter int DATA_W       = 512,
    parameter int USER_W       = 10,
    parameter int COMMIT_DEPTH = 8,
    parameter int A_WEIGHT     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    pcie_ss_axis_if.sink                          tx_a_if,
    pcie_ss_axis_if.sink                          tx_b_if,
    pcie_ss_axis_if.source                        tx_if,
    output logic                                  commit_valid,
    input  logic                                  commit_ready,
    output logic [9:0]                            commit_tag,
    output pcie_ss_hdr_pkg::ReqHdr_pf_vf_info_t   commit_pf_vf,
    output logic                                  commit_overflow
);
    import pcie_ss_hdr_pkg::*;

    localparam int PTR_W = $clog2(COMMIT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0] A_W4 = 4'(A_WEIGHT);

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] keep;
        logic [USER_W-1:0]   user;
        logic                last;
    } beat_t;

    typedef struct packed {
        logic [9:0]         tag;
        ReqHdr_pf_vf_info_t pf_vf;
    } rec_t;

    typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

    state_t             state_q, state_d;
    logic [3:0]         a_cnt_q, a_cnt_d;
    logic               run_q, run_d;
    logic               is_wr_q, is_wr_d;
    logic [9:0]         tag_q, tag_d;
    ReqHdr_pf_vf_info_t pf_vf_q, pf_vf_d;
    logic [CNT_W-1:0]   resv_q, resv_d, cnt_q, cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               ovf_q, ovf_d;
    logic               out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    beat_t              out_q, out_d, skid_q, skid_d;
    rec_t               mem [COMMIT_DEPTH];

    logic               in_ready, a_rdy, b_rdy, sel_b, a_acc, b_acc;
    logic               slot_free, a_elig, sop_is_wr, cur_is_wr;
    logic               reserve, push, pop, full, wr_en;
    logic [CNT_W:0]     used;
    PCIe_ReqHdr_t       hdr;
    rec_t               sop_rec, cur_rec, rd_rec;
    beat_t              beat_a, beat_b, in_beat;
    logic               unused_hdr_bits;

    // run_q holds every tready low until the first clock after reset release.
    assign in_ready  = run_q && !skid_vld_q;
    assign beat_a    = '{tx_a_if.tdata, tx_a_if.tkeep, tx_a_if.tuser_vendor, tx_a_if.tlast};
    assign beat_b    = '{tx_b_if.tdata, tx_b_if.tkeep, tx_b_if.tuser_vendor, tx_b_if.tlast};
    assign hdr       = PCIe_ReqHdr_t'(tx_a_if.tdata[255:0]);
    assign sop_is_wr = func_is_mwr_req(hdr.fmt_type);
    assign sop_rec   = '{{hdr.tag_h, hdr.tag_m, hdr.tag_l}, '{hdr.vf_num, hdr.vf_active, hdr.pf_num}};
    assign unused_hdr_bits = ^{hdr.rsvd_hi, hdr.host_addr, hdr.req_id, hdr.length};

    // A counts against capacity for records already queued and packets in flight.
    assign used      = {1'b0, cnt_q} + {1'b0, resv_q};
    assign slot_free = used < (CNT_W + 1)'(COMMIT_DEPTH);
    assign a_elig    = tx_a_if.tvalid && slot_free;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        a_cnt_d = a_cnt_q;
        a_rdy   = 1'b0;
        b_rdy   = 1'b0;
        sel_b   = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_elig && (!tx_b_if.tvalid || a_cnt_q < A_W4)) begin
                    a_rdy = in_ready;
                end else if (tx_b_if.tvalid) begin
                    b_rdy = in_ready;
                    sel_b = 1'b1;
                end
            end
            LOCK_A:  a_rdy = in_ready;
            LOCK_B: begin
                b_rdy = in_ready;
                sel_b = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        a_acc = a_rdy && tx_a_if.tvalid;
        b_acc = b_rdy && tx_b_if.tvalid;
        if (state_q == IDLE) begin
            if (a_acc) begin
                a_cnt_d = (a_cnt_q == 4'hF) ? a_cnt_q : a_cnt_q + 4'd1;
                if (!tx_a_if.tlast) state_d = LOCK_A;
            end else if (b_acc) begin
                a_cnt_d = '0;
                if (!tx_b_if.tlast) state_d = LOCK_B;
            end
        end else if ((a_acc && tx_a_if.tlast) || (b_acc && tx_b_if.tlast)) begin
            state_d = IDLE;
        end
    end

    // Header fields are live on the SOP beat and latched for the rest of the packet.
    assign cur_is_wr = (state_q == IDLE) ? sop_is_wr : is_wr_q;
    assign cur_rec   = (state_q == IDLE) ? sop_rec : '{tag_q, pf_vf_q};
    assign reserve   = (state_q == IDLE) && a_acc && sop_is_wr;
    assign push      = a_acc && tx_a_if.tlast && cur_is_wr;
    assign pop       = commit_valid && commit_ready;
    assign full      = cnt_q == CNT_W'(COMMIT_DEPTH);
    assign wr_en     = push && (!full || pop);

    always_comb begin
        run_d    = 1'b1;
        is_wr_d  = is_wr_q;
        tag_d    = tag_q;
        pf_vf_d  = pf_vf_q;
        if (reserve || ((state_q == IDLE) && a_acc)) begin
            is_wr_d = sop_is_wr;
            tag_d   = sop_rec.tag;
            pf_vf_d = sop_rec.pf_vf;
        end
        resv_d   = resv_q + CNT_W'(reserve) - CNT_W'(push);
        cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        ovf_d    = ovf_q || (push && full && !pop);
    end

    // Two-entry skid: the second slot absorbs the beat taken while tready drops.
    assign in_beat = sel_b ? beat_b : beat_a;
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (skid_vld_q) begin
            if (out_vld_q && tx_if.tready) begin
                out_d      = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (a_acc || b_acc) begin
            if (!out_vld_q || tx_if.tready) begin
                out_d     = in_beat;
                out_vld_d = 1'b1;
            end else begin
                skid_d     = in_beat;
                skid_vld_d = 1'b1;
            end
        end else if (out_vld_q && tx_if.tready) begin
            out_vld_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_cnt_q    <= '0;
            run_q      <= 1'b0;
            is_wr_q    <= 1'b0;
            tag_q      <= '0;
            pf_vf_q    <= '0;
            resv_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_q      <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_cnt_q    <= a_cnt_d;
            run_q      <= run_d;
            is_wr_q    <= is_wr_d;
            tag_q      <= tag_d;
            pf_vf_q    <= pf_vf_d;
            resv_q     <= resv_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            out_vld_q  <= out_vld_d;
            out_q      <= out_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    // NOTE: storage (skid data, FIFO array) is not reset; valid flags guard every read of it.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
        if (wr_en) mem[wr_ptr_q] <= cur_rec;
    end

    assign rd_rec          = mem[rd_ptr_q];
    assign commit_valid    = cnt_q != '0;
    assign commit_tag      = commit_valid ? rd_rec.tag : '0;
    assign commit_pf_vf    = commit_valid ? rd_rec.pf_vf : '0;
    assign commit_overflow = ovf_q;

    assign tx_a_if.tready     = a_rdy;
    assign tx_b_if.tready     = b_rdy;
    assign tx_if.tvalid       = out_vld_q;
    assign tx_if.tdata        = out_q.data;
    assign tx_if.tkeep        = out_q.keep;
    assign tx_if.tuser_vendor = out_q.user;
    assign tx_if.tlast        = out_q.last;
endmodule

// File: tb/tb_pcie_tx_ab_commit_arb.sv
// Directed bench for pcie_tx_ab_commit_arb: a cycle task drives both sources from
// beat queues, logs every handshake, and the tests compare logs to hand values.
module tb_pcie_tx_ab_commit_arb;
    import pcie_ss_hdr_pkg::*;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [9:0]   user;
        logic         last;
    } beat_t;
    typedef struct { beat_t b; int cyc; } log_t;
    typedef struct {
        bit to_b; logic [7:0] fmt; logic [9:0] tag; logic [2:0] pf;
        logic [10:0] vf; logic vfa; int nb; int exp_n;
    } vec_t;

    logic clk, rst_n, commit_valid, commit_ready, commit_overflow;
    logic [9:0] commit_tag;
    ReqHdr_pf_vf_info_t commit_pf_vf;

    pcie_ss_axis_if #(.DATA_W(512), .USER_W(10)) a_if ();
    pcie_ss_axis_if #(.DATA_W(512), .USER_W(10)) b_if ();
    pcie_ss_axis_if #(.DATA_W(512), .USER_W(10)) t_if ();

    pcie_tx_ab_commit_arb #(.DATA_W(512), .USER_W(10), .COMMIT_DEPTH(8), .A_WEIGHT(2)) dut (
        .clk(clk), .rst_n(rst_n), .tx_a_if(a_if), .tx_b_if(b_if), .tx_if(t_if),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
        .commit_pf_vf(commit_pf_vf), .commit_overflow(commit_overflow));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int errors = 0, checks = 0, cyc = 0, cv_rise = -1;
    beat_t a_q[$], b_q[$];
    bit rdy_q[$];
    log_t a_log[$], out_log[$];
    logic [24:0] cm_log[$];
    bit a_en, b_en, cr_en, a_acc, b_acc, prev_stall, prev_cv;
    beat_t prev_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ReqHdr_pf_vf_info_t mk_pfvf(input logic [2:0] pf, input logic [10:0] vf, input logic vfa);
        ReqHdr_pf_vf_info_t r;
        r.pf_num = pf; r.vf_num = vf; r.vf_active = vfa;
        return r;
    endfunction

    task automatic mk_pkt(input bit to_b, input logic [7:0] fmt, input logic [9:0] tag, input logic [2:0] pf,
                          input logic [10:0] vf, input logic vfa, input int nb, input int id);
        PCIe_ReqHdr_t h;
        beat_t bt;
        h = '0;
        h.fmt_type = fmt;
        {h.tag_h, h.tag_m, h.tag_l} = tag;
        h.pf_num = pf; h.vf_num = vf; h.vf_active = vfa; h.length = 10'(nb);
        for (int i = 0; i < nb; i++) begin
            bt.data[511:480] = {8'(to_b), 8'(id), 8'(i), 8'hA5};
            bt.data[479:256] = {7{32'(id * 256 + i)}};
            bt.data[255:0]   = (i == 0) ? 256'(h) : {8{32'hC0DE0000 | 32'(i)}};
            bt.keep = (i == nb - 1) ? 64'h0000_0000_FFFF_FFFF : '1;
            bt.user = 10'(id + i);
            bt.last = (i == nb - 1);
            if (to_b) b_q.push_back(bt); else a_q.push_back(bt);
        end
    endtask

    task automatic cycle();
        beat_t cur;
        @(negedge clk);
        cyc++;
        if (a_acc) a_q.delete(0);
        if (b_acc) b_q.delete(0);
        if (a_en && a_q.size() > 0) begin
            a_if.tvalid = 1'b1; {a_if.tdata, a_if.tkeep, a_if.tuser_vendor, a_if.tlast} = a_q[0];
        end else begin
            a_if.tvalid = 1'b0; {a_if.tdata, a_if.tkeep, a_if.tuser_vendor, a_if.tlast} = '0;
        end
        if (b_en && b_q.size() > 0) begin
            b_if.tvalid = 1'b1; {b_if.tdata, b_if.tkeep, b_if.tuser_vendor, b_if.tlast} = b_q[0];
        end else begin
            b_if.tvalid = 1'b0; {b_if.tdata, b_if.tkeep, b_if.tuser_vendor, b_if.tlast} = '0;
        end
        t_if.tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        commit_ready = cr_en;
        #1;
        cur = {t_if.tdata, t_if.tkeep, t_if.tuser_vendor, t_if.tlast};
        if (prev_stall) check("tx_hold_stable", 64'(t_if.tvalid && (cur == prev_beat)), 64'd1);
        a_acc = a_if.tvalid && a_if.tready;
        b_acc = b_if.tvalid && b_if.tready;
        if (a_acc) a_log.push_back('{a_q[0], cyc});
        if (t_if.tvalid && t_if.tready) out_log.push_back('{cur, cyc});
        if (commit_valid && commit_ready) cm_log.push_back({commit_tag, commit_pf_vf});
        if (commit_valid && !prev_cv) cv_rise = cyc;
        prev_cv = commit_valid;
        prev_stall = t_if.tvalid && !t_if.tready;
        prev_beat = cur;
    endtask

    task automatic clear_tb();
        a_q.delete(); b_q.delete(); rdy_q.delete();
        a_log.delete(); out_log.delete(); cm_log.delete();
        a_en = 0; b_en = 0; cr_en = 0; a_acc = 0; b_acc = 0;
        prev_stall = 0; prev_cv = 0; cv_rise = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_tb();
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        clear_tb();
    endtask

    task automatic run_until_idle(input string name, input int maxc);
        int n = 0;
        while ((a_q.size() > 0 || b_q.size() > 0 || t_if.tvalid) && n < maxc) begin
            cycle();
            n++;
        end
        if (n >= maxc) check({name, "_timeout"}, 64'd0, 64'd1);
        repeat (3) cycle();
    endtask

    function automatic logic [23:0] tag_of(input beat_t b);
        return b.data[511:488];
    endfunction

    function automatic int count_sop(input int src);
        int n = 0;
        foreach (out_log[i])
            if (out_log[i].b.data[495:488] == 8'd0 && out_log[i].b.data[511:504] == 8'(src)) n++;
        return n;
    endfunction

    initial begin
        vec_t vt[8];
        beat_t exp_beats[$];
        logic [23:0] exp_seq[$];
        int n, n0;

        // Reset with both sources presenting beats: every output must stay 0.
        rst_n = 1'b0;
        clear_tb();
        mk_pkt(0, 8'h40, 10'h111, 3'd1, 11'd1, 1'b1, 2, 60);
        mk_pkt(1, 8'h00, 10'h112, 3'd0, 11'd0, 1'b0, 1, 61);
        a_en = 1; b_en = 1; cr_en = 1;
        repeat (3) cycle();
        check("rst_tx_tvalid", t_if.tvalid, 0);
        check("rst_a_tready", a_if.tready, 0);
        check("rst_b_tready", b_if.tready, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_commit_overflow", commit_overflow, 0);
        check("rst_commit_tag", commit_tag, 0);

        // Single A MWr, 3 beats, B idle.
        do_reset();
        mk_pkt(0, 8'h40, 10'h2A5, 3'd1, 11'd3, 1'b1, 3, 1);
        a_en = 1;
        run_until_idle("t1", 40);
        check("t1_in_beats", a_log.size(), 3);
        check("t1_out_beats", out_log.size(), 3);
        for (int i = 0; i < 3 && i < out_log.size() && i < a_log.size(); i++) begin
            check("t1_beat_data", 64'(out_log[i].b == a_log[i].b), 64'd1);
            check("t1_beat_latency", 64'(out_log[i].cyc - a_log[i].cyc), 64'd1);
        end
        if (a_log.size() == 3) check("t1_commit_rise", 64'(cv_rise - a_log[2].cyc), 64'd1);
        check("t1_commit_valid", commit_valid, 1);
        check("t1_commit_tag", commit_tag, 10'h2A5);
        check("t1_commit_pf_vf", commit_pf_vf, mk_pfvf(3'd1, 11'd3, 1'b1));
        cr_en = 1;
        repeat (2) cycle();
        check("t1_commit_popped", cm_log.size(), 1);
        check("t1_commit_empty", commit_valid, 0);

        // Weighted arbitration, A_WEIGHT=2, 1-beat then multi-beat packets.
        do_reset();
        for (int i = 0; i < 4; i++) mk_pkt(0, 8'h00, 10'(i), 3'd0, 11'd0, 1'b0, 1, i);
        for (int i = 0; i < 2; i++) mk_pkt(1, 8'h00, 10'(i), 3'd0, 11'd0, 1'b0, 1, i);
        a_en = 1; b_en = 1;
        run_until_idle("t2a", 40);
        exp_seq = '{24'h000000, 24'h000100, 24'h010000, 24'h000200, 24'h000300, 24'h010100};
        check("t2_out_count", out_log.size(), 6);
        for (int i = 0; i < 6 && i < out_log.size(); i++) check("t2_order", tag_of(out_log[i].b), exp_seq[i]);
        out_log.delete();
        mk_pkt(0, 8'h00, 10'h4, 3'd0, 11'd0, 1'b0, 3, 4);
        mk_pkt(0, 8'h00, 10'h5, 3'd0, 11'd0, 1'b0, 3, 5);
        mk_pkt(1, 8'h00, 10'h2, 3'd0, 11'd0, 1'b0, 2, 2);
        mk_pkt(1, 8'h00, 10'h3, 3'd0, 11'd0, 1'b0, 2, 3);
        run_until_idle("t2b", 60);
        exp_seq = '{24'h000400, 24'h000401, 24'h000402, 24'h000500, 24'h000501, 24'h000502,
                    24'h010200, 24'h010201, 24'h010300, 24'h010301};
        check("t2_mb_count", out_log.size(), 10);
        for (int i = 0; i < 10 && i < out_log.size(); i++) check("t2_mb_order", tag_of(out_log[i].b), exp_seq[i]);

        // Commit FIFO backpressure: 12 A writes, 6 B reads, consumer stalled.
        do_reset();
        for (int i = 0; i < 12; i++) mk_pkt(0, 8'h40, 10'(10'h100 + i), 3'(i % 8), 11'(i), 1'b1, 2, i);
        for (int i = 0; i < 6; i++) mk_pkt(1, 8'h20, 10'(10'h200 + i), 3'd0, 11'd0, 1'b0, 1, i);
        a_en = 1; b_en = 1;
        repeat (60) cycle();
        check("t3_a_pkts_blocked", count_sop(0), 8);
        check("t3_b_pkts_flowed", count_sop(1), 6);
        check("t3_a_tvalid", a_if.tvalid, 1);
        check("t3_a_tready_low", a_if.tready, 0);
        check("t3_commit_valid", commit_valid, 1);
        check("t3_overflow_stalled", commit_overflow, 0);
        cr_en = 1;
        n = 0;
        while (cm_log.size() < 12 && n < 300) begin
            cycle();
            n++;
        end
        run_until_idle("t3", 100);
        check("t3_commit_count", cm_log.size(), 12);
        for (int i = 0; i < 12 && i < cm_log.size(); i++)
            check("t3_commit_order", cm_log[i], {10'(10'h100 + i), mk_pfvf(3'(i % 8), 11'(i), 1'b1)});
        check("t3_a_pkts_total", count_sop(0), 12);
        check("t3_overflow_final", commit_overflow, 0);

        // Table: only A memory writes commit; reads, messages and B writes do not.
        do_reset();
        vt[0] = '{1'b0, 8'h00, 10'h010, 3'd0, 11'd0,     1'b0, 2, 0};
        vt[1] = '{1'b0, 8'h30, 10'h020, 3'd0, 11'd0,     1'b0, 1, 0};
        vt[2] = '{1'b0, 8'h40, 10'h001, 3'd2, 11'd5,     1'b1, 3, 1};
        vt[3] = '{1'b0, 8'h20, 10'h030, 3'd0, 11'd0,     1'b0, 1, 0};
        vt[4] = '{1'b0, 8'h70, 10'h040, 3'd0, 11'd0,     1'b0, 2, 0};
        vt[5] = '{1'b1, 8'h60, 10'h050, 3'd1, 11'd1,     1'b1, 2, 0};
        vt[6] = '{1'b0, 8'h60, 10'h3FF, 3'd7, 11'h7FF,   1'b1, 1, 1};
        vt[7] = '{1'b0, 8'h40, 10'h000, 3'd0, 11'd0,     1'b0, 2, 1};
        a_en = 1; b_en = 1; cr_en = 1;
        for (int v = 0; v < 8; v++) begin
            n0 = cm_log.size();
            mk_pkt(vt[v].to_b, vt[v].fmt, vt[v].tag, vt[v].pf, vt[v].vf, vt[v].vfa, vt[v].nb, 20 + v);
            run_until_idle("t4", 40);
            check("t4_commit_count", cm_log.size() - n0, vt[v].exp_n);
            if (vt[v].exp_n == 1 && cm_log.size() > n0)
                check("t4_commit_rec", cm_log[n0], {vt[v].tag, mk_pfvf(vt[v].pf, vt[v].vf, vt[v].vfa)});
            if (v == 4) begin
                check("t4_mixed_one_commit", cm_log.size(), 1);
                if (cm_log.size() > 0) check("t4_mixed_tag", cm_log[0][24:15], 10'h001);
            end
        end
        check("t4_overflow", commit_overflow, 0);

        // tx_if.tready toggles during a 4-beat B packet; A waits for B tlast.
        do_reset();
        mk_pkt(1, 8'h00, 10'h070, 3'd0, 11'd0, 1'b0, 4, 7);
        mk_pkt(0, 8'h00, 10'h080, 3'd0, 11'd0, 1'b0, 2, 8);
        exp_beats = b_q;
        foreach (a_q[i]) exp_beats.push_back(a_q[i]);
        rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        b_en = 1;
        cycle();
        a_en = 1;
        run_until_idle("t5", 60);
        check("t5_out_count", out_log.size(), 6);
        for (int i = 0; i < 6 && i < out_log.size(); i++)
            check("t5_beat", 64'(out_log[i].b == exp_beats[i]), 64'd1);

        // Asynchronous reset in the middle of an A write.
        do_reset();
        mk_pkt(0, 8'h40, 10'h2F0, 3'd2, 11'd2, 1'b1, 4, 9);
        a_en = 1;
        n = 0;
        while (a_log.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        check("t6_two_beats_in", a_log.size(), 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_tx_tvalid", t_if.tvalid, 0);
        check("t6_rst_a_tready", a_if.tready, 0);
        check("t6_rst_b_tready", b_if.tready, 0);
        check("t6_rst_commit_valid", commit_valid, 0);
        check("t6_rst_overflow", commit_overflow, 0);
        clear_tb();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        check("t6_post_commit_valid", commit_valid, 0);
        mk_pkt(0, 8'h40, 10'h155, 3'd3, 11'd1, 1'b0, 2, 10);
        a_en = 1; cr_en = 1;
        run_until_idle("t6", 40);
        check("t6_fresh_count", cm_log.size(), 1);
        if (cm_log.size() > 0) check("t6_fresh_rec", cm_log[0], {10'h155, mk_pfvf(3'd3, 11'd1, 1'b0)});
        check("t6_out_beats", out_log.size(), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
